// File: rtl/dds_iq_if.sv
// Sample-side bundle of the quadrature DDS: tuning/phase controls, baseband in, I/Q out.
// Latency: none (wires only).
// Backpressure: none; the sink must accept every valid_o sample.
interface dds_iq_if #(
  parameter int BB_DATA_WIDTH   = 8,
  parameter int PHASE_INC_WIDTH = 16,
  parameter int PHASE_ACC_WIDTH = 16,
  parameter int LUT_PHASE_WIDTH = 10,
  parameter int SIN_ROM_WIDTH   = 8
);
  localparam int OUT_WIDTH = BB_DATA_WIDTH + SIN_ROM_WIDTH + 1;

  logic                               ce_i;
  logic signed [BB_DATA_WIDTH-1:0]    bb_data_i;
  logic [PHASE_INC_WIDTH-1:0]         phase_inc_i;
  logic                               phase_inc_ena_i;
  logic [PHASE_ACC_WIDTH-1:0]         phase_load_i;
  logic                               phase_load_ena_i;
  logic [LUT_PHASE_WIDTH-1:0]         phase_offset_i;
  logic signed [OUT_WIDTH-1:0]        i_data_o;
  logic signed [OUT_WIDTH-1:0]        q_data_o;
  logic                               valid_o;
  logic                               phase_wrap_o;

  // DDS side
  modport slave (
    input  ce_i, bb_data_i, phase_inc_i, phase_inc_ena_i,
           phase_load_i, phase_load_ena_i, phase_offset_i,
    output i_data_o, q_data_o, valid_o, phase_wrap_o
  );

  // Sample source / DAC side
  modport master (
    output ce_i, bb_data_i, phase_inc_i, phase_inc_ena_i,
           phase_load_i, phase_load_ena_i, phase_offset_i,
    input  i_data_o, q_data_o, valid_o, phase_wrap_o
  );
endinterface

// File: rtl/dds_iq.sv
// Quadrature DDS: baseband sample times cos/sin from one folded quarter-wave table.
// Latency: 4 cycles from a ce_i sample to valid_o, independent of ce_i gaps.
// Backpressure: none; the pipeline advances every cycle and ce_i only marks valid samples.
module dds_iq #(
  parameter int                         BB_DATA_WIDTH     = 8,
  parameter int                         PHASE_INC_WIDTH   = 16,
  parameter int                         PHASE_ACC_WIDTH   = 16,
  parameter logic [PHASE_ACC_WIDTH-1:0] PHASE_INITIAL     = '0,
  parameter int                         LUT_PHASE_WIDTH   = 10,
  parameter int                         SIN_ROM_WIDTH     = 8,
  parameter string                      SIN_ROM_INIT_FILE = "dds_qsin_rom.mem"
) (
  input  logic    clk_i,
  input  logic    rst_i,
  dds_iq_if.slave bus_io
);

  localparam int ACC_W     = PHASE_ACC_WIDTH;
  localparam int LUT_W     = LUT_PHASE_WIDTH;
  localparam int IDX_W     = LUT_PHASE_WIDTH - 2;
  localparam int ROM_DEPTH = 1 << IDX_W;
  localparam int MAG_W     = SIN_ROM_WIDTH;
  localparam int TRIG_W    = SIN_ROM_WIDTH + 1;
  localparam int OUT_W     = BB_DATA_WIDTH + SIN_ROM_WIDTH + 1;

  // ---------------------------------------------------------------------------
  // Quarter-wave table. Words are computed at elaboration with the same
  // expression the image file is generated from, so the table needs no preload
  // and always matches LUT_PHASE_WIDTH / SIN_ROM_WIDTH. The half-sample offset
  // keeps every word non-zero and makes rom[~k] the exact mirror of rom[k].
  // ---------------------------------------------------------------------------
  function automatic logic [MAG_W-1:0] rom_word(input int k);
    real amp;
    real ang;
    amp = $itor((1 << MAG_W) - 1);
    ang = 2.0 * 3.14159265358979323846 * ($itor(k) + 0.5) / $itor(1 << LUT_W);
    return MAG_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [MAG_W-1:0] rom_tbl [ROM_DEPTH];

  for (genvar gk = 0; gk < ROM_DEPTH; gk++) begin : g_rom
    localparam logic [MAG_W-1:0] WORD = rom_word(gk);
    assign rom_tbl[gk] = WORD;
  end

  // An image name is only meaningful to flows that ship the table separately;
  // the computed table above is used in either case.
  if (SIN_ROM_INIT_FILE == "") begin : g_no_image_name
  end

  // ---------------------------------------------------------------------------
  // Pipeline stage records
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic                            vld;
    logic signed [BB_DATA_WIDTH-1:0] bb;
    logic [LUT_W-1:0]                phase;
  } s1_t;

  typedef struct packed {
    logic                            vld;
    logic signed [BB_DATA_WIDTH-1:0] bb;
    logic [MAG_W-1:0]                sin_mag;
    logic [MAG_W-1:0]                cos_mag;
    logic                            sin_neg;
    logic                            cos_neg;
  } s2_t;

  typedef struct packed {
    logic                            vld;
    logic signed [BB_DATA_WIDTH-1:0] bb;
    logic signed [TRIG_W-1:0]        sin_val;
    logic signed [TRIG_W-1:0]        cos_val;
  } s3_t;

  // Phase accumulator and tuning word
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [PHASE_INC_WIDTH-1:0] inc_q, inc_d;
  logic                       wrap_q, wrap_d;
  logic [ACC_W:0]             acc_sum;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;

  logic signed [OUT_W-1:0] i_q, i_d;
  logic signed [OUT_W-1:0] q_q, q_d;
  logic                    valid_q, valid_d;

  // Stage-2 fold helpers
  logic [1:0]       sin_quad;
  logic [1:0]       cos_quad;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] sin_addr;
  logic [IDX_W-1:0] cos_addr;

  // Stage-4 operands, sign-extended to the product width
  logic signed [OUT_W-1:0] bb_ext;
  logic signed [OUT_W-1:0] sin_ext;
  logic signed [OUT_W-1:0] cos_ext;

  // Accumulator next state: load beats increment; wrap only on an increment carry.
  always_comb begin
    acc_d   = acc_q;
    inc_d   = inc_q;
    wrap_d  = 1'b0;
    acc_sum = {1'b0, acc_q} + {1'b0, ACC_W'(inc_q)};
    if (bus_io.phase_load_ena_i) begin
      acc_d = bus_io.phase_load_i;
    end else if (bus_io.ce_i) begin
      acc_d  = acc_sum[ACC_W-1:0];
      wrap_d = acc_sum[ACC_W];
    end
    // New tuning word takes effect from the next cycle's increment.
    if (bus_io.phase_inc_ena_i) begin
      inc_d = bus_io.phase_inc_i;
    end
  end

  // Stage 1: tap the pre-update accumulator with the sample and offset.
  always_comb begin
    s1_d       = '0;
    s1_d.vld   = bus_io.ce_i;
    s1_d.bb    = bus_io.bb_data_i;
    s1_d.phase = acc_q[ACC_W-1 -: LUT_W] + bus_io.phase_offset_i;
  end

  // Stage 2: fold the phase into a table index for sin and for cos (quadrant+1).
  always_comb begin
    sin_quad     = s1_q.phase[LUT_W-1 -: 2];
    cos_quad     = sin_quad + 2'd1;
    idx          = s1_q.phase[IDX_W-1:0];
    sin_addr     = sin_quad[0] ? ~idx : idx;
    cos_addr     = cos_quad[0] ? ~idx : idx;
    s2_d         = '0;
    s2_d.vld     = s1_q.vld;
    s2_d.bb      = s1_q.bb;
    s2_d.sin_mag = rom_tbl[sin_addr];
    s2_d.cos_mag = rom_tbl[cos_addr];
    s2_d.sin_neg = sin_quad[1];
    s2_d.cos_neg = cos_quad[1];
  end

  // Stage 3: apply the quadrant sign to the unsigned magnitudes.
  always_comb begin
    s3_d         = '0;
    s3_d.vld     = s2_q.vld;
    s3_d.bb      = s2_q.bb;
    s3_d.sin_val = s2_q.sin_neg ? -$signed({1'b0, s2_q.sin_mag}) : $signed({1'b0, s2_q.sin_mag});
    s3_d.cos_val = s2_q.cos_neg ? -$signed({1'b0, s2_q.cos_mag}) : $signed({1'b0, s2_q.cos_mag});
  end

  // Stage 4: full-precision products; outputs hold between valid samples.
  always_comb begin
    bb_ext  = OUT_W'($signed(s3_q.bb));
    sin_ext = OUT_W'($signed(s3_q.sin_val));
    cos_ext = OUT_W'($signed(s3_q.cos_val));
    i_d     = i_q;
    q_d     = q_q;
    valid_d = s3_q.vld;
    if (s3_q.vld) begin
      i_d = bb_ext * cos_ext;
      q_d = bb_ext * sin_ext;
    end
  end

  // All state registers; reset clears valid bits and outputs and discards in-flight samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= PHASE_INITIAL;
      inc_q   <= '0;
      wrap_q  <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      i_q     <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      wrap_q  <= wrap_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      i_q     <= i_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign bus_io.i_data_o     = i_q;
  assign bus_io.q_data_o     = q_q;
  assign bus_io.valid_o      = valid_q;
  assign bus_io.phase_wrap_o = wrap_q;

endmodule

// File: tb/tb_dds_iq.sv
// Self-checking bench for dds_iq: directed scenarios plus a randomized run against a reference model.
// Latency: the reference model delays each sample by 4 clocks.
// Backpressure: none; every valid_o sample is consumed.
module tb_dds_iq;

  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dds_iq_if #(
    .BB_DATA_WIDTH(8), .PHASE_INC_WIDTH(16), .PHASE_ACC_WIDTH(16),
    .LUT_PHASE_WIDTH(10), .SIN_ROM_WIDTH(8)
  ) bus ();

  dds_iq #(
    .BB_DATA_WIDTH(8), .PHASE_INC_WIDTH(16), .PHASE_ACC_WIDTH(16),
    .PHASE_INITIAL(16'h0000), .LUT_PHASE_WIDTH(10), .SIN_ROM_WIDTH(8),
    .SIN_ROM_INIT_FILE("dds_qsin_rom.mem")
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: phase in turns of 2^16, a 4-deep delay line of products.
  int m_acc, m_inc;
  bit p_vld [4];
  int p_i   [4];
  int p_q   [4];
  int e_i, e_q;
  bit e_vld, e_wrap;
  int got_i[$];
  int got_q[$];

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // Ideal amplitude-255 sine/cosine at the centre of lookup bin p (0..1023).
  function automatic int sin_ref(input int p);
    return rnd(255.0 * $sin(2.0 * PI * ($itor(p) + 0.5) / 1024.0));
  endfunction

  function automatic int cos_ref(input int p);
    return rnd(255.0 * $cos(2.0 * PI * ($itor(p) + 0.5) / 1024.0));
  endfunction

  // One clock: advance the model with the inputs currently driven, then step the DUT.
  task automatic cyc();
    int ph, ni, nq;
    bit nv, nw;
    nv = 0; ni = 0; nq = 0; nw = 0;
    if (rst) begin
      m_acc = 0;
      m_inc = 0;
      for (int s = 0; s < 4; s++) p_vld[s] = 0;
      e_i = 0;
      e_q = 0;
    end else begin
      if (bus.ce_i) begin
        ph = ((m_acc >> 6) + int'(bus.phase_offset_i)) % 1024;
        nv = 1;
        ni = int'(bus.bb_data_i) * cos_ref(ph);
        nq = int'(bus.bb_data_i) * sin_ref(ph);
      end
      if (bus.phase_load_ena_i) begin
        m_acc = int'(bus.phase_load_i);
      end else if (bus.ce_i) begin
        nw    = (m_acc + m_inc) > 65535;
        m_acc = (m_acc + m_inc) % 65536;
      end
      if (bus.phase_inc_ena_i) m_inc = int'(bus.phase_inc_i);
      for (int s = 3; s > 0; s--) begin
        p_vld[s] = p_vld[s-1];
        p_i[s]   = p_i[s-1];
        p_q[s]   = p_q[s-1];
      end
      p_vld[0] = nv;
      p_i[0]   = ni;
      p_q[0]   = nq;
      if (p_vld[3]) begin
        e_i = p_i[3];
        e_q = p_q[3];
      end
    end
    e_vld  = p_vld[3];
    e_wrap = nw;
    @(posedge clk);
    #1;
    if (bus.valid_o) begin
      got_i.push_back(int'($signed(bus.i_data_o)));
      got_q.push_back(int'($signed(bus.q_data_o)));
    end
  endtask

  task automatic idle_inputs();
    bus.ce_i             = 1'b0;
    bus.bb_data_i        = '0;
    bus.phase_inc_i      = '0;
    bus.phase_inc_ena_i  = 1'b0;
    bus.phase_load_i     = '0;
    bus.phase_load_ena_i = 1'b0;
    bus.phase_offset_i   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    got_i.delete();
    got_q.delete();
  endtask

  task automatic latch_inc(input int inc);
    bus.phase_inc_i     = 16'(inc);
    bus.phase_inc_ena_i = 1'b1;
    cyc();
    bus.phase_inc_ena_i = 1'b0;
  endtask

  task automatic test_reset();
    rst                  = 1'b1;
    bus.ce_i             = 1'b1;
    bus.bb_data_i        = 8'sd77;
    bus.phase_load_ena_i = 1'b1;
    bus.phase_load_i     = 16'h1234;
    bus.phase_inc_ena_i  = 1'b1;
    bus.phase_inc_i      = 16'h4000;
    for (int n = 0; n < 3; n++) cyc();
    n_vec++;
    if (bus.valid_o !== 1'b0 || bus.phase_wrap_o !== 1'b0 || bus.i_data_o !== '0 || bus.q_data_o !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b wrap=%b i=%0d q=%0d, required 0 0 0 0",
               bus.valid_o, bus.phase_wrap_o, $signed(bus.i_data_o), $signed(bus.q_data_o));
    end
    rst = 1'b0;
    idle_inputs();
    bus.ce_i = 1'b1;
    bus.bb_data_i = 8'sd1;
    cyc();
    for (int n = 0; n < 6; n++) begin
      bus.ce_i = 1'b0;
      cyc();
    end
    // accumulator must have been PHASE_INITIAL (0) and tuning word 0 after reset
    n_vec++;
    if (got_q.size() != 1 || got_q[0] != sin_ref(0) || got_i[0] != cos_ref(0)) begin
      n_err++;
      $display("FAIL reset_acc: samples=%0d first q=%0d i=%0d, required 1 sample q=%0d i=%0d",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 0, (got_i.size() > 0) ? got_i[0] : 0,
               sin_ref(0), cos_ref(0));
    end
  endtask

  task automatic test_const_tone();
    do_reset();
    bus.bb_data_i = 8'sd100;
    bus.ce_i      = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cyc();
      n_vec++;
      if (bus.valid_o !== (n >= 3)) begin
        n_err++;
        $display("FAIL tone_valid cycle %0d: got %b, required %b", n, bus.valid_o, (n >= 3));
      end
      n_vec++;
      if (n >= 3 && ($signed(bus.i_data_o) != 25500 || $signed(bus.q_data_o) != 100)) begin
        n_err++;
        $display("FAIL tone_data cycle %0d: i=%0d q=%0d, required 25500 100",
                 n, $signed(bus.i_data_o), $signed(bus.q_data_o));
      end else if (n < 3 && (bus.i_data_o !== '0 || bus.q_data_o !== '0)) begin
        n_err++;
        $display("FAIL tone_pre cycle %0d: i=%0d q=%0d, required 0 0",
                 n, $signed(bus.i_data_o), $signed(bus.q_data_o));
      end
    end
  endtask

  task automatic test_quadrature();
    int qs[4] = '{1, 255, -1, -255};
    int is[4] = '{255, -1, -255, 1};
    do_reset();
    latch_inc(16'h4000);
    bus.bb_data_i = 8'sd1;
    bus.ce_i      = 1'b1;
    for (int n = 0; n < 16; n++) begin
      cyc();
      n_vec++;
      if (bus.phase_wrap_o !== (n % 4 == 3)) begin
        n_err++;
        $display("FAIL quad_wrap cycle %0d: got %b, required %b", n, bus.phase_wrap_o, (n % 4 == 3));
      end
    end
    bus.ce_i = 1'b0;
    for (int n = 0; n < 4; n++) cyc();
    n_vec++;
    if (got_q.size() != 16) begin
      n_err++;
      $display("FAIL quad_count: got %0d samples, required 16", got_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_vec++;
        if (got_q[k] != qs[k % 4] || got_i[k] != is[k % 4]) begin
          n_err++;
          $display("FAIL quad_seq %0d: q=%0d i=%0d, required q=%0d i=%0d",
                   k, got_q[k], got_i[k], qs[k % 4], is[k % 4]);
        end
      end
    end
  endtask

  task automatic test_load_offset();
    int eq[4] = '{-32640, -32640, 128, 128};
    int ei[4] = '{128, 128, 32640, 32640};
    do_reset();
    bus.bb_data_i        = -8'sd128;
    bus.phase_load_i     = 16'h4000;
    bus.phase_load_ena_i = 1'b1;
    cyc();
    bus.phase_load_ena_i = 1'b0;
    bus.ce_i             = 1'b1;
    bus.phase_offset_i   = 10'd0;
    cyc();
    cyc();
    bus.phase_offset_i   = 10'd256;
    cyc();
    cyc();
    bus.ce_i = 1'b0;
    for (int n = 0; n < 4; n++) cyc();
    n_vec++;
    if (got_q.size() != 4) begin
      n_err++;
      $display("FAIL load_count: got %0d samples, required 4", got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (got_q[k] != eq[k] || got_i[k] != ei[k]) begin
          n_err++;
          $display("FAIL load_offset %0d: q=%0d i=%0d, required q=%0d i=%0d",
                   k, got_q[k], got_i[k], eq[k], ei[k]);
        end
      end
    end
  endtask

  task automatic test_ce_gaps();
    bit pat[9] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
    int ph[3]  = '{0, 256, 512};
    do_reset();
    latch_inc(16'h4000);
    bus.bb_data_i = 8'sd1;
    for (int n = 0; n < 9; n++) begin
      bus.ce_i = pat[n];
      cyc();
      n_vec++;
      if (bus.valid_o !== ((n >= 3) ? pat[n-3] : 1'b0)) begin
        n_err++;
        $display("FAIL gap_valid cycle %0d: got %b, required %b",
                 n, bus.valid_o, ((n >= 3) ? pat[n-3] : 1'b0));
      end
    end
    n_vec++;
    if (got_q.size() != 3) begin
      n_err++;
      $display("FAIL gap_count: got %0d samples, required 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got_q[k] != sin_ref(ph[k]) || got_i[k] != cos_ref(ph[k])) begin
          n_err++;
          $display("FAIL gap_seq %0d: q=%0d i=%0d, required q=%0d i=%0d",
                   k, got_q[k], got_i[k], sin_ref(ph[k]), cos_ref(ph[k]));
        end
      end
    end
  endtask

  task automatic test_load_with_ce();
    int ph[4] = '{0, 256, 768, 0};
    do_reset();
    latch_inc(16'h4000);
    bus.bb_data_i = 8'sd3;
    bus.ce_i      = 1'b1;
    cyc();
    bus.phase_load_i     = 16'hC000;
    bus.phase_load_ena_i = 1'b1;
    cyc();
    bus.phase_load_ena_i = 1'b0;
    cyc();
    cyc();
    bus.ce_i = 1'b0;
    for (int n = 0; n < 4; n++) cyc();
    n_vec++;
    if (got_q.size() != 4) begin
      n_err++;
      $display("FAIL loadce_count: got %0d samples, required 4", got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (got_q[k] != 3 * sin_ref(ph[k]) || got_i[k] != 3 * cos_ref(ph[k])) begin
          n_err++;
          $display("FAIL loadce_seq %0d: q=%0d i=%0d, required q=%0d i=%0d",
                   k, got_q[k], got_i[k], 3 * sin_ref(ph[k]), 3 * cos_ref(ph[k]));
        end
      end
    end
  endtask

  task automatic test_inc_with_ce();
    int ph[4] = '{0, 256, 384, 512};
    do_reset();
    latch_inc(16'h4000);
    bus.bb_data_i       = -8'sd5;
    bus.ce_i            = 1'b1;
    bus.phase_inc_i     = 16'h2000;
    bus.phase_inc_ena_i = 1'b1;
    cyc();
    bus.phase_inc_ena_i = 1'b0;
    cyc();
    cyc();
    cyc();
    bus.ce_i = 1'b0;
    for (int n = 0; n < 4; n++) cyc();
    n_vec++;
    if (got_q.size() != 4) begin
      n_err++;
      $display("FAIL incce_count: got %0d samples, required 4", got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (got_q[k] != -5 * sin_ref(ph[k]) || got_i[k] != -5 * cos_ref(ph[k])) begin
          n_err++;
          $display("FAIL incce_seq %0d: q=%0d i=%0d, required q=%0d i=%0d",
                   k, got_q[k], got_i[k], -5 * sin_ref(ph[k]), -5 * cos_ref(ph[k]));
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    latch_inc(16'h4000);
    bus.bb_data_i = 8'sd7;
    bus.ce_i      = 1'b1;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.ce_i = 1'b0;
    for (int n = 0; n < 8; n++) begin
      n_vec++;
      if (bus.valid_o !== 1'b0 || bus.i_data_o !== '0 || bus.q_data_o !== '0 || bus.phase_wrap_o !== 1'b0) begin
        n_err++;
        $display("FAIL midrun_flush cycle %0d: valid=%b i=%0d q=%0d wrap=%b, required 0 0 0 0",
                 n, bus.valid_o, $signed(bus.i_data_o), $signed(bus.q_data_o), bus.phase_wrap_o);
      end
      cyc();
    end
    // tuning word was cleared, so two samples both sit at PHASE_INITIAL
    bus.ce_i = 1'b1;
    cyc();
    cyc();
    bus.ce_i = 1'b0;
    for (int n = 0; n < 4; n++) cyc();
    n_vec++;
    if (got_q.size() != 2 || got_q[0] != 7 * sin_ref(0) || got_q[1] != 7 * sin_ref(0)) begin
      n_err++;
      $display("FAIL midrun_after: samples=%0d first q=%0d, required 2 samples q=%0d",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 0, 7 * sin_ref(0));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      rst                  = ($urandom_range(0, 99) == 0);
      bus.ce_i             = ($urandom_range(0, 3) != 0);
      bus.bb_data_i        = 8'($urandom);
      bus.phase_inc_ena_i  = ($urandom_range(0, 7) == 0);
      bus.phase_inc_i      = 16'($urandom);
      bus.phase_load_ena_i = ($urandom_range(0, 15) == 0);
      bus.phase_load_i     = 16'($urandom);
      bus.phase_offset_i   = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom);
      cyc();
      n_vec++;
      if (bus.valid_o !== e_vld) begin
        n_err++;
        $display("FAIL rand_valid cycle %0d: got %b, required %b", n, bus.valid_o, e_vld);
      end
      n_vec++;
      if (bus.phase_wrap_o !== e_wrap) begin
        n_err++;
        $display("FAIL rand_wrap cycle %0d: got %b, required %b", n, bus.phase_wrap_o, e_wrap);
      end
      n_vec++;
      if (bus.i_data_o !== 17'(e_i) || bus.q_data_o !== 17'(e_q)) begin
        n_err++;
        $display("FAIL rand_data cycle %0d: i=%0d q=%0d, required i=%0d q=%0d",
                 n, $signed(bus.i_data_o), $signed(bus.q_data_o), e_i, e_q);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Dense ce_i with a changing tuning word and offsets every cycle.
    do_reset();
    latch_inc(16'h1357);
    for (int n = 0; n < 40; n++) begin
      bus.ce_i            = 1'b1;
      bus.bb_data_i       = 8'($urandom);
      bus.phase_offset_i  = 10'($urandom);
      bus.phase_inc_ena_i = (n % 5 == 0);
      bus.phase_inc_i     = 16'($urandom);
      cyc();
      n_vec++;
      if (bus.valid_o !== e_vld || bus.i_data_o !== 17'(e_i) || bus.q_data_o !== 17'(e_q)
          || bus.phase_wrap_o !== e_wrap) begin
        n_err++;
        $display("FAIL b2b cycle %0d: v=%b i=%0d q=%0d w=%b, required v=%b i=%0d q=%0d w=%b",
                 n, bus.valid_o, $signed(bus.i_data_o), $signed(bus.q_data_o), bus.phase_wrap_o,
                 e_vld, e_i, e_q, e_wrap);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_const_tone();
    test_quadrature();
    test_load_offset();
    test_ce_gaps();
    test_load_with_ce();
    test_inc_with_ce();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
